stream_tx: RTL
==============

# stream_tx

Transmit-side AXI4-Stream master that sends computed results back to the DMA S2MM channel. It is the counterpart of the MM2S receive path. It buffers 64-bit result words from the compute pipeline in a small FIFO and emits them as one packet of exactly `tx_len` beats. `tlast` marks the final beat, and a one-cycle `send_finish` pulse returns to the main controller. It sits between the output stage of the accelerator datapath and the S2MM port of the AXI DMA.

## Interface
- `FIFO_AW`, 4: FIFO address width; depth = 2^FIFO_AW = 16 words.
- `LEN_W`, 16: width of the packet-length field, in beats.
- `sclk`  in  1  system clock; every register is clocked on its rising edge.
- `s_rst_n`  in  1  reset, asynchronous, active-low.
- `tx_start`  in  1  one-cycle request from the main controller; samples `tx_len`.
- `tx_len`  in  LEN_W  number of 64-bit beats in the packet; only valid with `tx_start`.
- `result_data`  in  64  result word from the datapath.
- `result_vld`  in  1  `result_data` is valid; a write occurs when `result_vld & result_rdy`.
- `result_rdy`  out  1  block can accept a result word this cycle.
- `m_axis_s2mm_tdata`  out  64  stream data.
- `m_axis_s2mm_tkeep`  out  8  byte enables.
- `m_axis_s2mm_tvalid`  out  1  stream valid.
- `m_axis_s2mm_tready`  in  1  DMA ready.
- `m_axis_s2mm_tlast`  out  1  final beat of the packet.
- `tx_busy`  out  1  high in SEND and DONE.
- `send_finish`  out  1  one-cycle pulse after the last beat handshake.

## Operation
- FSM states are IDLE, SEND and DONE.
  - IDLE → SEND on `tx_start & (tx_len != 0)`. The transition latches `len_r = tx_len` and clears `in_cnt`, `out_cnt` and the FIFO pointers.
  - `tx_start` with `tx_len == 0` is ignored: the FSM stays in IDLE and no `send_finish` is produced.
  - SEND → DONE on the handshake (`tvalid & tready`) of the beat where `out_cnt == len_r-1`.
  - DONE → IDLE unconditionally after one cycle; `send_finish` = 1 in DONE only.
  - `tx_start` in SEND or DONE is ignored.
- Input side:
  - `result_rdy = (state==SEND) & (fifo_cnt < 2^FIFO_AW) & (in_cnt < len_r)`.
  - Each write increments `in_cnt`. Words beyond `len_r` are never accepted.
  - In IDLE and DONE, `result_rdy` = 0.
- FIFO:
  - First-word-fall-through, depth 2^FIFO_AW, with a `fifo_cnt` of FIFO_AW+1 bits.
  - Full is evaluated before the same-cycle read: no write when `fifo_cnt` is at maximum, even if a read occurs that cycle.
  - Simultaneous write and read leaves `fifo_cnt` unchanged.
  - Pointers wrap modulo the depth.
- Output side:
  - `tvalid` = FIFO not empty while in SEND.
  - `tdata` = FIFO head word.
  - `tkeep` = 8'hFF whenever `tvalid` = 1, otherwise 8'h00.
  - `tlast = tvalid & (out_cnt == len_r-1)`.
  - Each handshake pops the FIFO and increments `out_cnt`.
- AXI rules:
  - Once `tvalid` is asserted, `tdata`, `tkeep`, `tlast` and `tvalid` stay stable until `tready`.
  - `tvalid` never depends combinationally on `tready`.
- Word order out equals word order in; no data is dropped or duplicated.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - All counters and pointers = 0.
  - `result_rdy`, `tvalid`, `tlast`, `tx_busy`, `send_finish` = 0.
  - `tkeep` = 0, `tdata` = 0.
- Latency:
  - A word written at edge N into an empty FIFO appears with `tvalid` = 1 in the cycle after edge N.
  - `send_finish` is high in the cycle after the last-beat handshake.
- Throughput: one beat per cycle sustained while `result_vld` and `tready` are both held high.
- Reset mid-packet: all in-flight data is discarded, `tvalid` drops at once, and the next `tx_start` begins a clean packet.
- `tready` low indefinitely: the FIFO fills to 16, `result_rdy` stays 0, and no state changes occur.

## Test plan
- Basic packet:
  - Stimulus: `tx_start` with `tx_len`=4; words 0xA0..0xA3 with `result_vld` continuous; `tready`=1.
  - Required: 4 beats in order, `tlast` only on 0xA3, `tkeep`=FF, `send_finish` one cycle later, `result_rdy`=0 after the 4th write.
- Backpressure:
  - Stimulus: `tx_len`=32; `tready`=0 for the first 30 cycles, then 1.
  - Required: `result_rdy` falls after exactly 16 writes; all 32 words arrive in order; `tlast` on beat 32.
- Random `tready` toggling:
  - Stimulus: `tx_len`=10.
  - Required: `tdata`, `tlast` and `tvalid` are held stable on every stalled cycle; 10 handshakes in total; one `send_finish`.
- Boundary lengths:
  - `tx_len`=1 → single beat with `tlast`=1.
  - `tx_len`=0 → no state change, no `send_finish`.
  - `tx_start` during SEND → ignored; the packet length is unchanged.
- Extra input:
  - Stimulus: `result_vld` held high after the packet is fully accepted (`tx_len`=3).
  - Required: only 3 words are written, and `result_rdy` stays 0 until the next `tx_start`.
- Reset mid-packet:
  - Stimulus: assert `s_rst_n`=0 after 5 of 8 beats.
  - Required: `tvalid`/`tlast`/`busy` go to 0 asynchronously. A following `tx_len`=2 packet then sends exactly its 2 new words with `tlast` on the 2nd.

Source files
------------

// File: rtl/stream_tx.sv
// stream_tx: AXI4-Stream master for the S2MM return path.
//
// Result words from the compute pipeline are buffered in a first-word-fall-
// through FIFO and sent as one packet of exactly tx_len beats, with tlast on
// the final beat. A one-cycle send_finish pulse follows the last handshake.
//
// Handshakes: a transfer happens on a rising sclk edge where valid and ready
// are both high; valid never depends combinationally on ready, and while
// valid is high without ready, the payload (tdata/tkeep/tlast) is held.
//
// Ports
//   sclk, s_rst_n          clock, asynchronous active-low reset
//   tx_start, tx_len       packet request and its length in beats
//   result_data/vld/rdy    result word input (write on vld & rdy)
//   m_axis_s2mm_*          AXI4-Stream master to the DMA
//   tx_busy                high while a packet is in SEND or DONE
//   send_finish            one-cycle pulse after the last beat
//   dbg_state_o            current FSM state, for observation
module stream_tx #(
    parameter int FIFO_AW = 4,
    parameter int LEN_W   = 16
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    input  logic             tx_start,
    input  logic [LEN_W-1:0] tx_len,
    input  logic [63:0]      result_data,
    input  logic             result_vld,
    output logic             result_rdy,
    output logic [63:0]      m_axis_s2mm_tdata,
    output logic [7:0]       m_axis_s2mm_tkeep,
    output logic             m_axis_s2mm_tvalid,
    input  logic             m_axis_s2mm_tready,
    output logic             m_axis_s2mm_tlast,
    output logic             tx_busy,
    output logic             send_finish,
    output logic [1:0]       dbg_state_o
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   in_cnt_q, in_cnt_d;
    logic [LEN_W-1:0]   out_cnt_q, out_cnt_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   fifo_cnt_q, fifo_cnt_d;
    logic [63:0]        mem_q [DEPTH];

    logic in_send;
    logic fifo_full;
    logic fifo_empty;
    logic wr_en;
    logic rd_en;
    logic last_beat;
    logic start_ok;

    assign in_send    = (state_q == ST_SEND);
    assign fifo_full  = (fifo_cnt_q == FULL_CNT);
    assign fifo_empty = (fifo_cnt_q == '0);
    // A zero-length request is dropped entirely.
    assign start_ok   = tx_start & (tx_len != '0);
    assign last_beat  = (out_cnt_q == (len_q - 1'b1));

    // Full is judged on the registered count, so a same-cycle pop never
    // opens a slot for a write.
    assign result_rdy = in_send & ~fifo_full & (in_cnt_q < len_q);
    assign wr_en      = result_vld & result_rdy;

    assign m_axis_s2mm_tvalid = in_send & ~fifo_empty;
    assign rd_en              = m_axis_s2mm_tvalid & m_axis_s2mm_tready;
    assign m_axis_s2mm_tlast  = m_axis_s2mm_tvalid & last_beat;
    assign m_axis_s2mm_tkeep  = m_axis_s2mm_tvalid ? 8'hFF : 8'h00;
    // Data is masked while invalid so it reads as zero out of reset.
    assign m_axis_s2mm_tdata  = m_axis_s2mm_tvalid ? mem_q[rd_ptr_q] : 64'd0;

    assign tx_busy     = (state_q != ST_IDLE);
    assign send_finish = (state_q == ST_DONE);
    assign dbg_state_o = state_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;

        // wr_en and rd_en can only be high in SEND.
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            in_cnt_d = in_cnt_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            out_cnt_d = out_cnt_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d    = ST_SEND;
                    len_d      = tx_len;
                    in_cnt_d   = '0;
                    out_cnt_d  = '0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    fifo_cnt_d = '0;
                end
            end
            ST_SEND: begin
                if (rd_en && last_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Storage needs no reset: contents are only visible behind fifo_cnt.
    always_ff @(posedge sclk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= result_data;
        end
    end

endmodule
